// File: rtl/biriscv_npc_pkg.sv
// Shared types and helpers for the next-PC return address stack.
// Stack operation encoding, the empty-prediction value and the return-address adder.
package biriscv_npc_pkg;

  // Value presented on the prediction output while the stack is empty.
  localparam logic [63:0] RAS_INVALID = 64'd0;

  typedef enum logic [1:0] {
    RAS_OP_NONE    = 2'd0,
    RAS_OP_PUSH    = 2'd1,
    RAS_OP_POP     = 2'd2,
    RAS_OP_REPLACE = 2'd3
  } ras_op_e;

  // Return address is the call PC plus one instruction; callers truncate to their PC width.
  function automatic logic [63:0] ras_ret_addr(input logic [63:0] call_pc);
    return call_pc + 64'd4;
  endfunction

  function automatic ras_op_e ras_op(input logic push, input logic pop);
    ras_op_e op;
    case ({push, pop})
      2'b10:   op = RAS_OP_PUSH;
      2'b01:   op = RAS_OP_POP;
      2'b11:   op = RAS_OP_REPLACE;
      default: op = RAS_OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/biriscv_npc_ras_stack.sv
// One circular return-address stack with occupancy tracking and a whole-state load port.
// Priority: flush, then load, then the requested push/pop/replace.
module biriscv_npc_ras_stack
  import biriscv_npc_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  ras_op_e            op,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_entries [DEPTH],
  input  logic [DEPTH_W-1:0] load_tos,
  input  logic [DEPTH_W:0]   load_count,
  output logic [ADDR_W-1:0]  entries [DEPTH],
  output logic [DEPTH_W-1:0] tos,
  output logic [DEPTH_W:0]   count,
  output logic [ADDR_W-1:0]  next_entries [DEPTH],
  output logic [DEPTH_W-1:0] next_tos,
  output logic [DEPTH_W:0]   next_count,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [DEPTH_W:0] FULL = (DEPTH_W + 1)'(DEPTH);

  logic [DEPTH_W-1:0] tos_inc;
  logic               empty;

  assign tos_inc = tos + DEPTH_W'(1);
  assign empty   = (count == '0);

  always_comb begin
    next_entries = entries;
    next_tos     = tos;
    next_count   = count;
    overflow     = 1'b0;
    underflow    = 1'b0;
    if (flush) begin
      next_tos   = '0;
      next_count = '0;
    end else if (load_en) begin
      next_entries = load_entries;
      next_tos     = load_tos;
      next_count   = load_count;
    end else begin
      case (op)
        RAS_OP_PUSH, RAS_OP_REPLACE: begin
          // A replace on an empty stack has nothing to replace, so it degrades to a push.
          if (op == RAS_OP_REPLACE && !empty) begin
            next_entries[tos] = addr;
          end else begin
            next_tos              = tos_inc;
            next_entries[tos_inc] = addr;
            if (count == FULL) overflow = 1'b1;
            else               next_count = count + (DEPTH_W + 1)'(1);
          end
        end
        RAS_OP_POP: begin
          if (empty) begin
            underflow = 1'b1;
          end else begin
            next_tos   = tos - DEPTH_W'(1);
            next_count = count - (DEPTH_W + 1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '{default: '0};
      tos     <= '0;
      count   <= '0;
    end else begin
      entries <= next_entries;
      tos     <= next_tos;
      count   <= next_count;
    end
  end

endmodule

// File: rtl/biriscv_npc_ras.sv
// Return address stack for the next-PC unit: speculative stack restored from a committed stack.
// Optional overflow/underflow statistics are enabled by defining BIRISCV_RAS_STATS_EN.
module biriscv_npc_ras
  import biriscv_npc_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3,
  parameter int ADDR_W  = 32,
  parameter int FETCH_W = 2,
  parameter int SLOT_W  = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               spec_push_i,
  input  logic               spec_pop_i,
  input  logic               spec_accept_i,
  input  logic [ADDR_W-1:0]  spec_pc_i,
  input  logic [SLOT_W-1:0]  spec_slot_i,
  input  logic               commit_push_i,
  input  logic               commit_pop_i,
  input  logic [ADDR_W-1:0]  commit_pc_i,
  input  logic               restore_i,
  output logic               pred_valid_o,
  output logic [ADDR_W-1:0]  pred_pc_o,
  output logic [DEPTH_W:0]   count_o,
  output logic [15:0]        stat_overflow_o,
  output logic [15:0]        stat_underflow_o
);

  localparam int FETCH_W_UNUSED = FETCH_W;

  ras_op_e            spec_op, com_op;
  logic [ADDR_W-1:0]  spec_base, spec_ret, com_ret;
  logic               spec_pc_unused;

  logic [ADDR_W-1:0]  spec_entries [DEPTH];
  logic [DEPTH_W-1:0] spec_tos;
  logic [DEPTH_W:0]   spec_count;
  logic [ADDR_W-1:0]  spec_next_entries_unused [DEPTH];
  logic [DEPTH_W-1:0] spec_next_tos_unused;
  logic [DEPTH_W:0]   spec_next_count_unused;
  logic               spec_ovf, spec_unf;

  logic [ADDR_W-1:0]  com_entries [DEPTH];
  logic [DEPTH_W-1:0] com_tos;
  logic [DEPTH_W:0]   com_count;
  logic [ADDR_W-1:0]  com_next_entries [DEPTH];
  logic [DEPTH_W-1:0] com_next_tos;
  logic [DEPTH_W:0]   com_next_count;
  logic               com_ovf_unused, com_unf_unused;

  // The call sits at slot spec_slot_i of an aligned bundle; low PC bits are replaced by the slot.
  assign spec_base      = {spec_pc_i[ADDR_W-1:SLOT_W+2], spec_slot_i, 2'b00};
  assign spec_pc_unused = ^spec_pc_i[SLOT_W+1:0];
  assign spec_ret       = ADDR_W'(ras_ret_addr(64'(spec_base)));
  assign com_ret        = ADDR_W'(ras_ret_addr(64'(commit_pc_i)));

  assign spec_op = spec_accept_i ? ras_op(spec_push_i, spec_pop_i) : RAS_OP_NONE;
  assign com_op  = ras_op(commit_push_i, commit_pop_i);

  biriscv_npc_ras_stack #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .ADDR_W(ADDR_W)) u_com (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .flush        (flush_i),
    .op           (com_op),
    .addr         (com_ret),
    .load_en      (1'b0),
    .load_entries (com_entries),
    .load_tos     (com_tos),
    .load_count   (com_count),
    .entries      (com_entries),
    .tos          (com_tos),
    .count        (com_count),
    .next_entries (com_next_entries),
    .next_tos     (com_next_tos),
    .next_count   (com_next_count),
    .overflow     (com_ovf_unused),
    .underflow    (com_unf_unused)
  );

  // Restore loads the committed next-state so a commit in the same cycle is not lost.
  biriscv_npc_ras_stack #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .ADDR_W(ADDR_W)) u_spec (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .flush        (flush_i),
    .op           (spec_op),
    .addr         (spec_ret),
    .load_en      (restore_i),
    .load_entries (com_next_entries),
    .load_tos     (com_next_tos),
    .load_count   (com_next_count),
    .entries      (spec_entries),
    .tos          (spec_tos),
    .count        (spec_count),
    .next_entries (spec_next_entries_unused),
    .next_tos     (spec_next_tos_unused),
    .next_count   (spec_next_count_unused),
    .overflow     (spec_ovf),
    .underflow    (spec_unf)
  );

  assign pred_valid_o = (spec_count != '0);
  assign pred_pc_o    = pred_valid_o ? spec_entries[spec_tos] : RAS_INVALID[ADDR_W-1:0];
  assign count_o      = spec_count;

`ifdef BIRISCV_RAS_STATS_EN
  logic [15:0] ovf_cnt, unf_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic ev);
    return (ev && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // Statistics register boundary; only reset clears these
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      ovf_cnt <= sat_inc(ovf_cnt, spec_ovf);
      unf_cnt <= sat_inc(unf_cnt, spec_unf);
    end
  end

  assign stat_overflow_o  = ovf_cnt;
  assign stat_underflow_o = unf_cnt;
`else
  logic stats_unused;
  assign stats_unused     = spec_ovf | spec_unf;
  assign stat_overflow_o  = '0;
  assign stat_underflow_o = '0;
`endif

endmodule

// File: tb/tb_biriscv_npc_ras.sv
// Self-checking bench for biriscv_npc_ras: directed vector table, overflow sequence,
// randomized traffic against a queue-based stack model, and asynchronous reset.
module tb_biriscv_npc_ras;

  localparam int DEPTH = 8;
`ifdef BIRISCV_RAS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 0, spec_push_i = 0, spec_pop_i = 0, spec_accept_i = 0;
  logic [31:0] spec_pc_i = '0;
  logic [0:0]  spec_slot_i = '0;
  logic        commit_push_i = 0, commit_pop_i = 0, restore_i = 0;
  logic [31:0] commit_pc_i = '0;
  logic        pred_valid_o;
  logic [31:0] pred_pc_o;
  logic [3:0]  count_o;
  logic [15:0] stat_overflow_o, stat_underflow_o;

  always #5 clk = ~clk;

  biriscv_npc_ras dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .spec_push_i      (spec_push_i),
    .spec_pop_i       (spec_pop_i),
    .spec_accept_i    (spec_accept_i),
    .spec_pc_i        (spec_pc_i),
    .spec_slot_i      (spec_slot_i),
    .commit_push_i    (commit_push_i),
    .commit_pop_i     (commit_pop_i),
    .commit_pc_i      (commit_pc_i),
    .restore_i        (restore_i),
    .pred_valid_o     (pred_valid_o),
    .pred_pc_o        (pred_pc_o),
    .count_o          (count_o),
    .stat_overflow_o  (stat_overflow_o),
    .stat_underflow_o (stat_underflow_o)
  );

  typedef logic [31:0] aq_t [$];

  typedef struct {
    bit          fl, sp, spo, acc;
    logic [31:0] pc;
    bit          slot;
    bit          cp, cpo;
    logic [31:0] cpc;
    bit          rs;
    bit          ev;
    logic [31:0] epc;
    int          ecnt;
  } vec_t;

  vec_t vt [20];
  int   checks = 0;
  int   errors = 0;
  aq_t  spec_q, com_q;
  int   m_ovf = 0, m_unf = 0;

  function automatic vec_t mk(bit fl, bit sp, bit spo, bit acc, logic [31:0] pc, bit slot,
                              bit cp, bit cpo, logic [31:0] cpc, bit rs,
                              bit ev, logic [31:0] epc, int ecnt);
    vec_t v;
    v.fl = fl; v.sp = sp; v.spo = spo; v.acc = acc; v.pc = pc; v.slot = slot;
    v.cp = cp; v.cpo = cpo; v.cpc = cpc; v.rs = rs;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt;
    return v;
  endfunction

  // Bounded LIFO: at most DEPTH live addresses, the oldest is dropped on overflow.
  function automatic void apply_op(input aq_t qi, input bit push, input bit pop,
                                   input logic [31:0] a, output aq_t qo,
                                   output bit ovf, output bit unf);
    qo = qi; ovf = 0; unf = 0;
    if (push && pop && qo.size() != 0) begin
      qo[qo.size()-1] = a;
    end else if (push) begin
      qo.push_back(a);
      if (qo.size() > DEPTH) begin
        void'(qo.pop_front());
        ovf = 1;
      end
    end else if (pop) begin
      if (qo.size() != 0) void'(qo.pop_back());
      else unf = 1;
    end
  endfunction

  function automatic int exp_stat(int v);
    return STATS ? v : 0;
  endfunction

  task automatic model_update();
    logic [31:0] sa, ca;
    aq_t nq;
    bit  o, u;
    sa = (spec_pc_i & ~32'd7) + 32'(spec_slot_i) * 4 + 32'd4;
    ca = commit_pc_i + 32'd4;
    if (flush_i) begin
      spec_q.delete();
      com_q.delete();
    end else begin
      apply_op(com_q, commit_push_i, commit_pop_i, ca, nq, o, u);
      com_q = nq;
      if (restore_i) begin
        spec_q = com_q;
      end else if (spec_accept_i) begin
        apply_op(spec_q, spec_push_i, spec_pop_i, sa, nq, o, u);
        spec_q = nq;
        if (o && m_ovf < 65535) m_ovf++;
        if (u && m_unf < 65535) m_unf++;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit fl, input bit sp, input bit spo, input bit acc,
                      input logic [31:0] pc, input bit slot, input bit cp, input bit cpo,
                      input logic [31:0] cpc, input bit rs);
    flush_i = fl; spec_push_i = sp; spec_pop_i = spo; spec_accept_i = acc;
    spec_pc_i = pc; spec_slot_i = slot; commit_push_i = cp; commit_pop_i = cpo;
    commit_pc_i = cpc; restore_i = rs;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 32'(pred_valid_o), 32'(spec_q.size() != 0));
    check({tag, "_pc"}, pred_pc_o, (spec_q.size() != 0) ? spec_q[spec_q.size()-1] : 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'(spec_q.size()));
  endtask

  task automatic check_stats(input string tag, input int ovf, input int unf);
    check({tag, "_ovf"}, 32'(stat_overflow_o), 32'(exp_stat(ovf)));
    check({tag, "_unf"}, 32'(stat_underflow_o), 32'(exp_stat(unf)));
  endtask

  initial begin
    //        fl sp po ac pc        sl cp cpo cpc       rs   ev pc        cnt
    vt[0]  = mk(0, 1, 0, 1, 'h1000, 1, 0, 0, 'h0,    0,   1, 'h1008, 1);
    vt[1]  = mk(0, 0, 1, 1, 'h0,    0, 0, 0, 'h0,    0,   0, 'h0,    0);
    vt[2]  = mk(0, 0, 1, 1, 'h0,    0, 0, 0, 'h0,    0,   0, 'h0,    0);
    vt[3]  = mk(0, 0, 0, 0, 'h0,    0, 1, 0, 'h2000, 0,   0, 'h0,    0);
    vt[4]  = mk(0, 1, 0, 1, 'h3000, 0, 0, 0, 'h0,    0,   1, 'h3004, 1);
    vt[5]  = mk(0, 1, 0, 1, 'h3000, 1, 0, 0, 'h0,    0,   1, 'h3008, 2);
    vt[6]  = mk(0, 0, 0, 0, 'h0,    0, 0, 0, 'h0,    1,   1, 'h2004, 1);
    vt[7]  = mk(0, 1, 0, 1, 'h5000, 0, 1, 0, 'h4000, 1,   1, 'h4004, 2);
    vt[8]  = mk(0, 1, 0, 1, 'h6000, 0, 0, 0, 'h0,    0,   1, 'h6004, 3);
    vt[9]  = mk(0, 0, 1, 1, 'h0,    0, 0, 0, 'h0,    0,   1, 'h4004, 2);
    vt[10] = mk(0, 1, 1, 1, 'h7000, 1, 0, 0, 'h0,    0,   1, 'h7008, 2);
    vt[11] = mk(0, 1, 0, 0, 'h8000, 0, 0, 0, 'h0,    0,   1, 'h7008, 2);
    vt[12] = mk(1, 1, 0, 1, 'h8000, 0, 1, 0, 'h1234, 0,   0, 'h0,    0);
    vt[13] = mk(0, 0, 0, 0, 'h0,    0, 0, 0, 'h0,    1,   0, 'h0,    0);
    vt[14] = mk(0, 1, 1, 1, 'h9000, 0, 0, 0, 'h0,    0,   1, 'h9004, 1);
    vt[15] = mk(0, 0, 1, 1, 'h0,    0, 0, 0, 'h0,    0,   0, 'h0,    0);
    vt[16] = mk(0, 0, 1, 1, 'h0,    0, 0, 1, 'h0,    0,   0, 'h0,    0);
    vt[17] = mk(0, 0, 0, 0, 'h0,    0, 1, 0, 'h100,  0,   0, 'h0,    0);
    vt[18] = mk(0, 0, 0, 0, 'h0,    0, 1, 0, 'h200,  0,   0, 'h0,    0);
    vt[19] = mk(0, 0, 0, 0, 'h0,    0, 0, 1, 'h0,    1,   1, 'h104,  1);

    #12 rst_ni = 1'b1;
    #1;
    check("reset_valid", 32'(pred_valid_o), 32'd0);
    check("reset_pc", pred_pc_o, 32'd0);
    check("reset_count", 32'(count_o), 32'd0);
    check_stats("reset", 0, 0);

    for (int i = 0; i < 20; i++) begin
      step(vt[i].fl, vt[i].sp, vt[i].spo, vt[i].acc, vt[i].pc, vt[i].slot,
           vt[i].cp, vt[i].cpo, vt[i].cpc, vt[i].rs);
      check($sformatf("vec%0d_valid", i), 32'(pred_valid_o), 32'(vt[i].ev));
      check($sformatf("vec%0d_pc", i), pred_pc_o, vt[i].epc);
      check($sformatf("vec%0d_count", i), 32'(count_o), 32'(vt[i].ecnt));
    end
    check_stats("table", 0, 2);

    // Nine pushes into an eight-deep stack, then drain it past empty.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 1, 32'hA000 + 32'(i) * 8, 0, 0, 0, 0, 0);
    check("ovf_count", 32'(count_o), 32'd8);
    check("ovf_top", pred_pc_o, 32'hA044);
    check_stats("ovf", 1, 2);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      check($sformatf("drain%0d_count", k), 32'(count_o), 32'(8 - k));
      check($sformatf("drain%0d_pc", k), pred_pc_o,
            (k < 8) ? 32'hA004 + 32'(8 - k) * 8 : 32'd0);
    end
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    check("drain_extra_valid", 32'(pred_valid_o), 32'd0);
    check_stats("drain", 1, 3);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
           $urandom_range(0, 7) != 0, $urandom, 1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 15) == 0);
      check_model($sformatf("rnd%0d", n));
    end
    check_stats("rnd", m_ovf, m_unf);

    step(0, 1, 0, 1, 32'hC000, 0, 1, 0, 32'hD000, 0);
    rst_ni = 1'b0;
    #1;
    spec_q.delete(); com_q.delete(); m_ovf = 0; m_unf = 0;
    check("async_rst_valid", 32'(pred_valid_o), 32'd0);
    check("async_rst_count", 32'(count_o), 32'd0);
    check_stats("async_rst", 0, 0);
    #1 rst_ni = 1'b1;
    step(0, 1, 0, 1, 32'hB000, 1, 0, 0, 0, 0);
    check("post_rst_pc", pred_pc_o, 32'hB008);
    check_model("post_rst");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("post_rst_restore_count", 32'(count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
